// File: rtl/emoji_pkg.sv
// Shared definitions for the board-to-board emoji link (transmitter and deframer).
package emoji_pkg;
  localparam int   EMOJI_W    = 4;
  localparam int   FRAME_BITS = 7;
  localparam logic LINE_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity: data plus this bit always carries an even count of ones.
  function automatic logic even_parity(input logic [EMOJI_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/emoji_serial_tx_baud.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero while clear is high.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic FPGA_clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick || clear) cnt_d = '0;
  end

  always_ff @(posedge FPGA_clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/emoji_serial_tx.sv
// Serial emoji transmitter: start, 4 data bits LSB first, even parity, stop.
module emoji_serial_tx
  import emoji_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit AUTO_SEND    = 1'b0
) (
  input  logic               FPGA_clock,
  input  logic               reset,
  input  logic [EMOJI_W-1:0] emoji_in,
  input  logic               send,
  output logic               busy,
  output logic               done,
  output logic               tx_line
);
  localparam int          BW       = $clog2(EMOJI_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(EMOJI_W - 1);

  tx_state_e          state_q, state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [EMOJI_W-1:0] shreg_q, shreg_d;
  logic [EMOJI_W-1:0] last_q, last_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               tick, trig;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .FPGA_clock (FPGA_clock),
    .reset      (reset),
    .clear      (state_q == IDLE),
    .tick       (tick)
  );

  assign trig    = send || (AUTO_SEND && (emoji_in != last_q));
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign tx_line = tx_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (trig) begin
        state_d = START;
        shreg_d = emoji_in;
        last_d  = emoji_in;
        par_d   = even_parity(emoji_in);
        tx_d    = 1'b0;
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shreg_q[0];
      end
      DATA: if (tick) begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          shreg_d   = shreg_q >> 1;
          tx_d      = shreg_q[1];
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = LINE_IDLE;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      last_q    <= '0;
      par_q     <= 1'b0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end
endmodule
